// File: rtl/mips_multicycle_core_if.sv
// Unified instruction/data word-memory port of mips_multicycle_core.
// The core drives the request side; the memory answers with data and a ready.
interface mips_multicycle_core_if #(
    parameter int ADDR_W = 5
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB over one ready-handshaked memory port.
// Optional ILLEGAL_TRAP_EN adds an illegal output and a HALT state for unsupported encodings.
module mips_multicycle_core #(
    parameter int ADDR_W   = 5,
    parameter int RESET_PC = 12,
    parameter int LOOP_END = 19,
    parameter int REG_AW   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_multicycle_core_if.master mem,
    output logic [ADDR_W-1:0]      pc,
    output logic [31:0]            result,
    output logic                   retire,
    output logic [ADDR_W-1:0]      retire_pc
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic                   illegal
`endif
);
    localparam logic [ADDR_W-1:0] LP_RESET = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] LP_END   = ADDR_W'(LOOP_END);
    localparam logic [REG_AW-1:0] LP_R31   = REG_AW'(31);
    localparam int                NREG     = 2**REG_AW;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
`ifdef ILLEGAL_TRAP_EN
        ,
        S_HALT   = 3'd5
`endif
    } state_t;

    state_t            r_state, w_state_nx;
    logic [31:0]       r_ir, r_a, r_b, r_val;
    logic              r_wr, r_load;
    logic [REG_AW-1:0] r_dst;
    logic [ADDR_W-1:0] r_next;
    logic [31:0]       r_rf [NREG];

    logic [5:0]        w_op, w_fn;
    logic [REG_AW-1:0] w_rs, w_rt, w_rd, w_dst;
    logic [4:0]        w_sh;
    logic [31:0]       w_imm, w_sum, w_val;
    logic [ADDR_W-1:0] w_pc1, w_jt, w_ea, w_next;
    logic              w_hs, w_wr, w_mem, w_store;
`ifdef ILLEGAL_TRAP_EN
    logic              w_ill;
`endif

    assign w_op  = r_ir[31:26];
    assign w_rs  = r_ir[21 +: REG_AW];
    assign w_rt  = r_ir[16 +: REG_AW];
    assign w_rd  = r_ir[11 +: REG_AW];
    assign w_sh  = r_ir[10:6];
    assign w_fn  = r_ir[5:0];
    assign w_imm = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_sum = r_a + w_imm;
    assign w_ea  = w_sum[ADDR_W-1:0];
    assign w_jt  = r_ir[ADDR_W-1:0];
    assign w_pc1 = pc + ADDR_W'(1);
    assign w_hs  = mem.mem_req & mem.mem_ready;

    function automatic logic [ADDR_W-1:0] wrap_pc(input logic [ADDR_W-1:0] a);
        wrap_pc = ((LOOP_END != 0) && (a == LP_END)) ? LP_RESET : a;
    endfunction

    // Execute-stage decode: write value, destination and next PC of the instruction in IR
    always_comb begin
        w_val   = 32'd0;
        w_wr    = 1'b0;
        w_dst   = w_rd;
        w_next  = w_pc1;
        w_mem   = 1'b0;
        w_store = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        w_ill   = 1'b0;
`endif
        case (w_op)
            6'b000000: begin
                w_wr = 1'b1;
                case (w_fn)
                    6'b100000: w_val = r_a + r_b;
                    6'b100010: w_val = r_a - r_b;
                    6'b100100: w_val = r_a & r_b;
                    6'b100101: w_val = r_a | r_b;
                    6'b000000: w_val = r_b << w_sh;
                    default: begin
                        w_wr = 1'b0;
`ifdef ILLEGAL_TRAP_EN
                        w_ill = 1'b1;
`endif
                    end
                endcase
            end
            6'b001000: begin w_val = w_sum; w_wr = 1'b1; w_dst = w_rt; end
            6'b100011: begin w_mem = 1'b1; w_wr = 1'b1; w_dst = w_rt; end
            6'b101011: begin w_mem = 1'b1; w_store = 1'b1; end
            6'b000100: begin
                if (r_a == r_b) w_next = w_pc1 + w_imm[ADDR_W-1:0];
                else            w_next = w_pc1;
            end
            6'b000010: w_next = w_jt;
            6'b000011: begin
                w_val  = {{(32-ADDR_W){1'b0}}, w_pc1};
                w_wr   = 1'b1;
                w_dst  = LP_R31;
                w_next = w_jt;
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                w_ill = 1'b1;
`else
                w_next = w_pc1;
`endif
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_state_nx;
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_FETCH:  if (w_hs) w_state_nx = S_DECODE; else w_state_nx = S_FETCH;
            S_DECODE: w_state_nx = S_EXEC;
            S_EXEC: begin
`ifdef ILLEGAL_TRAP_EN
                if (w_ill)      w_state_nx = S_HALT;
                else if (w_mem) w_state_nx = S_MEM;
                else            w_state_nx = S_WB;
`else
                if (w_mem) w_state_nx = S_MEM;
                else       w_state_nx = S_WB;
`endif
            end
            S_MEM:    if (w_hs) w_state_nx = S_WB; else w_state_nx = S_MEM;
            S_WB:     w_state_nx = S_FETCH;
            default:  w_state_nx = r_state;
        endcase
    end

    // Datapath, register file and registered memory-port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= LP_RESET;
            r_ir          <= 32'd0;
            r_a           <= 32'd0;
            r_b           <= 32'd0;
            r_val         <= 32'd0;
            r_wr          <= 1'b0;
            r_load        <= 1'b0;
            r_dst         <= {REG_AW{1'b0}};
            r_next        <= {ADDR_W{1'b0}};
            for (int i = 0; i < NREG; i++) r_rf[i] <= 32'd0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= {ADDR_W{1'b0}};
            mem.mem_wdata <= 32'd0;
            result        <= 32'd0;
            retire        <= 1'b0;
            retire_pc     <= {ADDR_W{1'b0}};
`ifdef ILLEGAL_TRAP_EN
            illegal       <= 1'b0;
`endif
        end else begin
            retire <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    // Only the first fetch after reset arrives here without a request raised
                    if (!mem.mem_req) begin
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= pc;
                    end else if (mem.mem_ready) begin
                        r_ir        <= mem.mem_rdata;
                        mem.mem_req <= 1'b0;
                    end
                end
                S_DECODE: begin
                    r_a <= r_rf[w_rs];
                    r_b <= r_rf[w_rt];
                end
                S_EXEC: begin
                    r_val  <= w_val;
                    r_wr   <= w_wr;
                    r_dst  <= w_dst;
                    r_next <= wrap_pc(w_next);
                    r_load <= w_mem & ~w_store;
                    if (w_mem) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= w_store;
                        mem.mem_addr  <= w_ea;
                        mem.mem_wdata <= r_b;
                    end
`ifdef ILLEGAL_TRAP_EN
                    if (w_ill) illegal <= 1'b1;
`endif
                end
                S_MEM: begin
                    if (w_hs) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        if (r_load) r_val <= mem.mem_rdata;
                    end
                end
                S_WB: begin
                    if (r_wr && (r_dst != {REG_AW{1'b0}})) r_rf[r_dst] <= r_val;
                    if (r_wr) result <= r_val;
                    retire       <= 1'b1;
                    retire_pc    <= pc;
                    pc           <= r_next;
                    mem.mem_req  <= 1'b1;
                    mem.mem_we   <= 1'b0;
                    mem.mem_addr <= r_next;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: retire scoreboard, store scoreboard and a
// second core instance with the loop wrap disabled.
module tb_mips_multicycle_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_last = 0;
    int b_cnt  = 0;

    mips_multicycle_core_if #(.ADDR_W(5)) bus_a ();
    mips_multicycle_core_if #(.ADDR_W(5)) bus_b ();

    logic [4:0]  pc_a, rpc_a, pc_b, rpc_b;
    logic [31:0] res_a, res_b;
    logic        ret_a, ret_b, rdy_a;
`ifdef ILLEGAL_TRAP_EN
    logic        ill_a, ill_b;
`endif
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];

    mips_multicycle_core #(.ADDR_W(5), .RESET_PC(12), .LOOP_END(19), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .mem(bus_a), .pc(pc_a), .result(res_a),
        .retire(ret_a), .retire_pc(rpc_a)
`ifdef ILLEGAL_TRAP_EN
        , .illegal(ill_a)
`endif
    );

    mips_multicycle_core #(.ADDR_W(5), .RESET_PC(12), .LOOP_END(0), .REG_AW(5)) dut_nowrap (
        .clk(clk), .rst(rst), .mem(bus_b), .pc(pc_b), .result(res_b),
        .retire(ret_b), .retire_pc(rpc_b)
`ifdef ILLEGAL_TRAP_EN
        , .illegal(ill_b)
`endif
    );

    assign bus_a.mem_rdata = mem_a[bus_a.mem_addr];
    assign bus_a.mem_ready = rdy_a;
    assign bus_b.mem_rdata = mem_b[bus_b.mem_addr];
    assign bus_b.mem_ready = 1'b1;

    typedef struct {
        logic [4:0]  pc;
        bit          cr;
        logic [31:0] res;
        logic [4:0]  nxt;
        int          gap;
    } exp_t;
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    exp_t sbq[$];
    wr_t  wq[$];

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
        enc_r = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        enc_i = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(input int op, input int t);
        enc_j = {6'(op), 26'(t)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ex(input int pc, input bit cr, input int res, input int nxt, input int gap);
        exp_t e;
        e.pc = 5'(pc); e.cr = cr; e.res = 32'(res); e.nxt = 5'(nxt); e.gap = gap;
        sbq.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("retire_timeout", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem_a[i] = 32'd0;
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus_a.mem_req && rdy_a && bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
    end

    // Retire scoreboard for the main core
    always @(negedge clk) begin
        if (ret_a) begin
            if (sbq.size() == 0) begin
                chk("unexpected_retire", 32'(rpc_a), 32'd99);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("retire_pc", 32'(rpc_a), 32'(e.pc));
                if (e.cr) chk("result", res_a, e.res);
                chk("next_req", 32'(bus_a.mem_req), 32'd1);
                chk("next_fetch", 32'(bus_a.mem_addr), 32'(e.nxt));
                chk("retire_gap", 32'(cyc - t_last), 32'(e.gap));
            end
            t_last = cyc;
        end
    end

    // Store scoreboard: a write handshake completes on the coming edge
    always @(negedge clk) begin
        if (!rst && bus_a.mem_req && bus_a.mem_we && rdy_a) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'(bus_a.mem_addr), 32'd99);
            end else begin
                wr_t w;
                w = wq.pop_front();
                chk("store_addr", 32'(bus_a.mem_addr), 32'(w.a));
                chk("store_data", bus_a.mem_wdata, w.d);
            end
        end
    end

    // Wrap-disabled core: j 18 at 12, then add at 18 must fetch 19
    always @(negedge clk) begin
        if (rst) begin
            b_cnt = 0;
        end else if (ret_b) begin
            b_cnt++;
            if (b_cnt == 1) begin
                chk("nowrap_rpc0", 32'(rpc_b), 32'd12);
                chk("nowrap_fetch0", 32'(bus_b.mem_addr), 32'd18);
            end else if (b_cnt == 2) begin
                chk("nowrap_rpc1", 32'(rpc_b), 32'd18);
                chk("nowrap_fetch1", 32'(bus_b.mem_addr), 32'd19);
            end
        end
    end

    initial begin
        int n;
        rdy_a = 1'b1;
        for (int i = 0; i < 32; i++) mem_b[i] = 32'd0;
        mem_b[12] = enc_j(2, 18);
        mem_b[18] = enc_r(0, 0, 1, 0, 32);

        // Load, ALU, store, r0 and wrap
        clear_mem();
        mem_a[0]  = 32'd9;
        mem_a[1]  = 32'd6;
        mem_a[12] = enc_i(35, 0, 1, 0);
        mem_a[13] = enc_i(35, 0, 2, 1);
        mem_a[14] = enc_r(1, 2, 3, 0, 32);
        mem_a[15] = enc_r(3, 1, 4, 0, 34);
        mem_a[16] = enc_i(43, 0, 3, 5);
        mem_a[17] = enc_i(35, 0, 5, 5);
        mem_a[18] = enc_i(8, 0, 0, 7);
        ex(12, 1, 9, 13, 6);
        ex(13, 1, 6, 14, 5);
        ex(14, 1, 15, 15, 4);
        ex(15, 1, 6, 16, 4);
        ex(16, 1, 6, 17, 5);
        ex(17, 1, 15, 18, 5);
        ex(18, 0, 0, 12, 4);
        ex(12, 1, 9, 13, 5);
        wq.push_back('{a: 5'd5, d: 32'd15});
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(bus_a.mem_req), 32'd0);
        chk("rst_pc", 32'(pc_a), 32'd12);
        chk("rst_result", res_a, 32'd0);
        chk("rst_retire", 32'(ret_a), 32'd0);
        rst = 1'b0;
        t_last = cyc;
        @(negedge clk);
        chk("first_req", 32'(bus_a.mem_req), 32'd1);
        chk("first_addr", 32'(bus_a.mem_addr), 32'd12);
        drain(300);
        chk("store_pending", 32'(wq.size()), 32'd0);

        // Fetch wait states, branches, jal, sll and or
        rst = 1'b1;
        @(negedge clk);
        clear_mem();
        mem_a[12] = enc_i(8, 0, 1, 1);
        mem_a[13] = enc_i(8, 3, 3, 1);
        mem_a[14] = enc_i(4, 3, 1, 2);
        mem_a[15] = enc_r(0, 1, 7, 4, 0);
        mem_a[16] = enc_r(7, 31, 8, 0, 37);
        mem_a[17] = enc_j(3, 13);
        ex(12, 1, 1, 13, 8);
        ex(13, 1, 1, 14, 4);
        ex(14, 1, 1, 17, 4);
        ex(17, 1, 18, 13, 4);
        ex(13, 1, 2, 14, 4);
        ex(14, 1, 2, 15, 4);
        ex(15, 1, 16, 16, 4);
        ex(16, 1, 18, 17, 4);
        rdy_a = 1'b0;
        rst = 1'b0;
        t_last = cyc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wait_req", 32'(bus_a.mem_req), 32'd1);
            chk("wait_addr", 32'(bus_a.mem_addr), 32'd12);
        end
        rdy_a = 1'b1;
        drain(300);

        // Reset while a load waits on the memory
        rst = 1'b1;
        @(negedge clk);
        clear_mem();
        mem_a[0]  = 32'd77;
        mem_a[12] = enc_i(8, 0, 1, 5);
        mem_a[13] = enc_i(35, 0, 2, 0);
        ex(12, 1, 5, 13, 5);
        rst = 1'b0;
        t_last = cyc;
        drain(100);
        n = 0;
        while (!(bus_a.mem_req && !bus_a.mem_we && bus_a.mem_addr == 5'd0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        rdy_a = 1'b0;
        chk("load_req_timeout", 32'(n < 50), 32'd1);
        repeat (2) @(negedge clk);
        chk("load_wait_req", 32'(bus_a.mem_req), 32'd1);
        chk("load_wait_addr", 32'(bus_a.mem_addr), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midmem_req", 32'(bus_a.mem_req), 32'd0);
        chk("midmem_pc", 32'(pc_a), 32'd12);
        chk("midmem_retire", 32'(ret_a), 32'd0);
        chk("midmem_result", res_a, 32'd0);
        mem_a[12] = enc_i(8, 1, 3, 3);
        mem_a[13] = 32'hFC00_0000;
        ex(12, 1, 3, 13, 5);
`ifndef ILLEGAL_TRAP_EN
        ex(13, 1, 3, 14, 4);
`endif
        rdy_a = 1'b1;
        rst = 1'b0;
        t_last = cyc;
        drain(100);
`ifdef ILLEGAL_TRAP_EN
        n = 0;
        while (ill_a !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("illegal_flag", 32'(ill_a), 32'd1);
        chk("illegal_pc", 32'(pc_a), 32'd13);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("halt_req", 32'(bus_a.mem_req), 32'd0);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
